uart_tx_arb: RTL

//  Round-robin arbiter/sequencer sharing the single UART transmitter among NUM_REQ byte sources
//  (CNN result reporter, debug echo, status). Picks a requester, latches its byte, pulses trmt,

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_arb_rr_pick.sv | 39 +++
 rtl/uart_tx_arb.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Holds the arbiter state encoding, the byte width and a small helper
// that advances a round-robin index with wrap-around.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CLR  = 2'd2,
    WAIT = 2'd3
  } arb_state_t;

  // Next round-robin position after idx, wrapping back to 0 after n-1.
  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker.
// Scans the request vector starting at the pointer position, wrapping
// around, and reports the first set bit as both one-hot and binary index.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW:0] sum;

  // Walk offsets from farthest to nearest so the closest request to the
  // pointer is the last one written and therefore wins.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    sum    = '0;
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (PW + 1)'(i);
      if (sum >= (PW + 1)'(N)) begin
        sum = sum - (PW + 1)'(N);
      end
      if (req[sum[PW-1:0]]) begin
        any = 1'b1;
        idx = sum[PW-1:0];
      end
    end
    if (any) begin
      onehot = N'(1) << idx;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// sources. A winner's byte is latched in IDLE, trmt and the matching gnt
// pulse together in SEND, CLR skips the stale tx_done left over from the
// previous frame, and WAIT holds until the UART reports the frame done.
// Optional feature: define UART_ARB_BURST_EN to keep the grant locked to
// one requester until it sends a byte flagged with req_last.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           trmt,
  output logic [UART_BYTE_W-1:0]         tx_data,
  input  logic                           tx_done,
  output logic                           busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t             state;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          win_idx;
  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic [PW-1:0]          pick_idx;
  logic                   pick_any;
  logic [UART_BYTE_W-1:0] pick_byte;

`ifdef UART_ARB_BURST_EN
  logic               locked;
  logic [NUM_REQ-1:0] lock_mask;
  logic               win_last;
  logic               pick_last;

  // While a message is in progress only the locked requester may win.
  always_comb begin
    eligible = locked ? (req & lock_mask) : req;
  end
`else
  logic unused_last;

  // Every byte is arbitrated afresh; message boundaries do not matter.
  always_comb begin
    eligible = req;
  end

  assign unused_last = ^req_last;
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req    (eligible),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Select the byte (and last flag) belonging to the current pick.
  always_comb begin
    pick_byte = '0;
`ifdef UART_ARB_BURST_EN
    pick_last = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == PW'(i)) begin
        pick_byte = req_data[i*UART_BYTE_W +: UART_BYTE_W];
`ifdef UART_ARB_BURST_EN
        pick_last = req_last[i];
`endif
      end
    end
  end

  // Arbiter FSM with registered trmt, gnt, tx_data and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      trmt    <= 1'b0;
      tx_data <= '0;
      busy    <= 1'b0;
      ptr     <= '0;
      win_idx <= '0;
`ifdef UART_ARB_BURST_EN
      locked    <= 1'b0;
      lock_mask <= '0;
      win_last  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          gnt  <= '0;
          trmt <= 1'b0;
          if (pick_any) begin
            win_idx <= pick_idx;
            tx_data <= pick_byte;
            gnt     <= pick_onehot;
            trmt    <= 1'b1;
            busy    <= 1'b1;
`ifdef UART_ARB_BURST_EN
            win_last <= pick_last;
`endif
            state   <= SEND;
          end
        end
        SEND: begin
          gnt  <= '0;
          trmt <= 1'b0;
`ifdef UART_ARB_BURST_EN
          if (!win_last) begin
            locked    <= 1'b1;
            lock_mask <= gnt;
          end else begin
            locked <= 1'b0;
            ptr    <= PW'(wrap_next(int'(win_idx), NUM_REQ));
          end
`else
          ptr <= PW'(wrap_next(int'(win_idx), NUM_REQ));
`endif
          state <= CLR;
        end
        CLR: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
